// File: rtl/uart_tx_scheduler_if.sv
// Signal bundle between the byte producers/serializer side and the TX scheduler.
// Handshake: a requester byte is taken on the cycle where req_valid[i] && req_ready[i] are both high.
interface uart_tx_scheduler_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic              ena;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              tx_start;
  logic [DW-1:0]     tx_data;
  logic              tx_done;
  logic [IW-1:0]     grant_id;
  logic              busy;
  logic              err;
  logic [1:0]        state_dbg;

  modport master (
    output ena, req_valid, req_data, tx_done,
    input  req_ready, tx_start, tx_data, grant_id, busy, err, state_dbg
  );

  modport slave (
    input  ena, req_valid, req_data, tx_done,
    output req_ready, tx_start, tx_data, grant_id, busy, err, state_dbg
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one UART TX serializer among NREQ byte producers,
// with a watchdog that abandons a frame whose tx_done never arrives.
module uart_tx_scheduler #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_scheduler_if.slave bus
);
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WDW = $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [IW:0]    NREQ_W  = (IW+1)'(NREQ);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   grant_q;
  logic [DW-1:0]   tx_data_q;
  logic [WDW-1:0]  wd;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW:0]     cand;
  logic [NREQ-1:0] ready_c;
  logic            tx_start_c;
  logic            err_c;
  logic            load;
  logic            ptr_adv;

  // Scan from ptr upward with wrap; first asserted request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!win_found && bus.req_valid[cand[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    ready_c    = '0;
    tx_start_c = 1'b0;
    err_c      = 1'b0;
    load       = 1'b0;
    ptr_adv    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ena && win_found) begin
          ready_c[win_idx] = 1'b1;
          load             = 1'b1;
          state_nxt        = START;
        end
      end
      START: begin
        tx_start_c = 1'b1;
        state_nxt  = WAIT_DONE;
      end
      WAIT_DONE: begin
        // A completion on the expiry cycle takes precedence over the abort.
        if (bus.tx_done) begin
          ptr_adv   = 1'b1;
          state_nxt = IDLE;
        end else if (wd == WD_LAST) begin
          err_c     = 1'b1;
          ptr_adv   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_q   <= '0;
      tx_data_q <= '0;
      wd        <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        tx_data_q <= bus.req_data[win_idx*DW +: DW];
        grant_q   <= win_idx;
      end
      if (state == START) wd <= '0;
      else if (state == WAIT_DONE) wd <= wd + 1'b1;
      if (ptr_adv) ptr <= (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
    end
  end

  assign bus.req_ready = ready_c;
  assign bus.tx_start  = tx_start_c;
  assign bus.err       = err_c;
  assign bus.tx_data   = tx_data_q;
  assign bus.grant_id  = grant_q;
  assign bus.busy      = (state != IDLE);
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: expected {grant_id, tx_data} per frame
// is queued by the stimulus and checked by a monitor on every tx_start.
module tb_uart_tx_scheduler;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int TOUT = 16;
  localparam int W    = 10;

  logic clk;
  logic rst_n;

  uart_tx_scheduler_if #(.NREQ(NREQ), .DW(DW)) bus ();

  uart_tx_scheduler #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int ready_cnt = 0;
  int err_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  logic [W-1:0] mon_got;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.tx_start) begin
        start_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_tx_start", 32'd1, 32'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          mon_got = {bus.grant_id, bus.tx_data};
          chk("frame_id_data", {22'd0, mon_got}, {22'd0, mon_exp});
        end
      end
      if (bus.req_ready != '0) begin
        ready_cnt++;
        chk("ready_onehot", {31'd0, $onehot(bus.req_ready)}, 32'd1);
        chk("ready_only_idle", {30'd0, bus.state_dbg}, 32'd0);
      end
      if (bus.err) err_cnt++;
    end
  end

  // driver tasks
  task automatic do_reset();
    rst_n         = 1'b0;
    bus.ena       = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.tx_done   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_outputs", {bus.tx_data, bus.grant_id, bus.tx_start, bus.err, bus.req_ready, bus.state_dbg},
        32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.tx_start) begin
        seen = 1'b1;
        break;
      end
    end
    chk("tx_start_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic send_done(input int gap);
    @(posedge clk);
    repeat (gap) @(posedge clk);
    #1 bus.tx_done = 1'b1;
    @(posedge clk);
    #1 bus.tx_done = 1'b0;
    @(negedge clk);
    chk("busy_after_done", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    bit saw;
    saw = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.req_ready != '0 || bus.tx_start || bus.busy) saw = 1'b1;
    end
    chk(name, {31'd0, saw}, 32'd0);
  endtask

  initial begin
    int got;
    // 1: single request
    do_reset();
    bus.req_valid = 4'b0100;
    bus.req_data  = 32'h00A5_0000;
    exp_q.push_back({2'd2, 8'hA5});
    @(negedge clk);
    chk("t1_ready", {28'd0, bus.req_ready}, 32'h4);
    @(posedge clk);
    #1 bus.req_valid = '0;
    wait_start();
    send_done(2);
    chk("t1_hold", {22'd0, bus.grant_id, bus.tx_data}, {22'd0, 2'd2, 8'hA5});

    // 2: fairness with all requesters valid
    do_reset();
    bus.req_valid = 4'b1111;
    bus.req_data  = 32'h1312_1110;
    exp_q.push_back({2'd0, 8'h10});
    exp_q.push_back({2'd1, 8'h11});
    exp_q.push_back({2'd2, 8'h12});
    exp_q.push_back({2'd3, 8'h13});
    exp_q.push_back({2'd0, 8'h10});
    for (int f = 0; f < 5; f++) begin
      wait_start();
      if (f == 4) bus.req_valid = '0;
      send_done(f % 3);
    end

    // 3: pointer skip (ptr=1 now)
    @(posedge clk);
    #1;
    bus.req_valid = 4'b0010;
    bus.req_data  = 32'h3300_2130;
    exp_q.push_back({2'd1, 8'h21});
    exp_q.push_back({2'd3, 8'h33});
    exp_q.push_back({2'd0, 8'h30});
    wait_start();
    bus.req_valid = 4'b1001;
    send_done(2);
    wait_start();
    send_done(0);
    wait_start();
    bus.req_valid = '0;
    send_done(1);

    // 4: watchdog abort, then completion on the expiry cycle
    @(posedge clk);
    #1;
    bus.req_valid = 4'b1100;
    bus.req_data  = 32'h5544_0000;
    exp_q.push_back({2'd2, 8'h44});
    exp_q.push_back({2'd3, 8'h55});
    wait_start();
    got = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.err) begin
        got = k;
        break;
      end
    end
    chk("t4_err_cycle", got, 32'd16);
    @(negedge clk);
    chk("t4_next_grant", {28'd0, bus.req_ready}, 32'h8);
    chk("t4_busy_idle", {31'd0, bus.busy}, 32'd0);
    @(posedge clk);
    #1 bus.req_valid = '0;
    wait_start();
    repeat (16) @(posedge clk);
    #1 bus.tx_done = 1'b1;
    @(negedge clk);
    chk("t4_done_beats_err", {31'd0, bus.err}, 32'd0);
    @(posedge clk);
    #1 bus.tx_done = 1'b0;
    @(negedge clk);
    chk("t4_busy_after", {31'd0, bus.busy}, 32'd0);
    chk("t4_err_pulses", err_cnt, 32'd1);

    // 5: ena gating (ptr=0 now)
    @(posedge clk);
    #1;
    bus.ena       = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_data  = 32'h1312_1110;
    expect_quiet("t5_ena_block", 10);
    exp_q.push_back({2'd0, 8'h10});
    exp_q.push_back({2'd1, 8'h11});
    @(posedge clk);
    #1 bus.ena = 1'b1;
    wait_start();
    bus.ena = 1'b0;
    send_done(3);
    expect_quiet("t5_idle_after_frame", 8);
    @(posedge clk);
    #1 bus.ena = 1'b1;
    wait_start();
    bus.req_valid = '0;
    send_done(0);

    // 6: reset during WAIT_DONE (ptr=2 now)
    @(posedge clk);
    #1;
    bus.req_valid = 4'b0001;
    bus.req_data  = 32'h0000_0066;
    exp_q.push_back({2'd0, 8'h66});
    wait_start();
    bus.req_valid = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_busy", {31'd0, bus.busy}, 32'd0);
    chk("t6_async_outputs", {bus.tx_data, bus.grant_id, bus.tx_start, bus.err, bus.req_ready, bus.state_dbg},
        32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 bus.tx_done = 1'b1;
    @(posedge clk);
    #1 bus.tx_done = 1'b0;
    expect_quiet("t6_no_restart", 10);

    // final report
    chk("queue_drained", exp_q.size(), 32'd0);
    chk("total_starts", start_cnt, 32'd14);
    chk("total_readies", ready_cnt, 32'd14);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
